// File: rtl/sample_linear_upsampler_if.sv
// Purpose: sample/ready bundle between the synth core, the linear upsampler
//          and the sigma-delta DAC.
// Signals:
//   sample_in_l/r   18b signed input samples, valid while sample_in_rdy is high
//   sample_in_rdy   one-cycle input strobe
//   sample_out_l/r  18b signed interpolated samples, registered
//   sample_out_rdy  one-cycle output strobe
//   underrun        one-cycle pulse: a frame started with no new input
//   overrun         one-cycle pulse: an unconsumed pending input was overwritten
// Modports: master = sample source / output sink, slave = upsampler.
interface sample_linear_upsampler_if;
  logic signed [17:0] sample_in_l;
  logic signed [17:0] sample_in_r;
  logic               sample_in_rdy;
  logic signed [17:0] sample_out_l;
  logic signed [17:0] sample_out_r;
  logic               sample_out_rdy;
  logic               underrun;
  logic               overrun;

  modport master (
    output sample_in_l, sample_in_r, sample_in_rdy,
    input  sample_out_l, sample_out_r, sample_out_rdy, underrun, overrun
  );

  modport slave (
    input  sample_in_l, sample_in_r, sample_in_rdy,
    output sample_out_l, sample_out_r, sample_out_rdy, underrun, overrun
  );
endinterface

// File: rtl/sample_linear_upsampler.sv
// Purpose: stereo linear-interpolation upsampler. Each input sample becomes the
//          target of a frame of 2^STEP_LOG2 outputs, one output every OUT_DIV clocks,
//          ramping linearly from the previous target to the new one.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    sample_linear_upsampler_if.slave (inputs, outputs, underrun/overrun)
// Parameters:
//   OUT_DIV    clocks between output strobes (>= 16)
//   STEP_LOG2  log2 of outputs per frame
module sample_linear_upsampler #(
  parameter int OUT_DIV   = 64,
  parameter int STEP_LOG2 = 4
) (
  input logic                      clk,
  input logic                      reset,
  sample_linear_upsampler_if.slave bus
);
  localparam int TW    = $clog2(OUT_DIV);
  localparam int AW    = 19 + STEP_LOG2;
  localparam int NCH   = 2;  // channel 0 = left, 1 = right

  logic [TW-1:0]        r_tick;
  logic [STEP_LOG2-1:0] r_step;
  logic                 r_pend_valid;
  logic                 r_rdy;
  logic                 r_under;
  logic                 r_over;

  // The previous target is not kept separately: it lives in the accumulator,
  // which is seeded with it at every frame load.
  logic [NCH-1:0][17:0] r_pend;
  logic [NCH-1:0][17:0] r_curr;
  logic [NCH-1:0][18:0] r_delta;
  logic [NCH-1:0][AW-1:0] r_acc;
  logic [NCH-1:0][17:0] r_out;

  logic                   w_emit;
  logic                   w_load;
  logic                   w_take;
  logic [NCH-1:0][17:0]   w_in;
  logic [NCH-1:0][17:0]   w_curr_new;
  logic [NCH-1:0][18:0]   w_delta_new;
  logic [NCH-1:0][AW-1:0] w_acc_nxt;

  assign w_emit = (r_tick == TW'(OUT_DIV - 1));
  assign w_load = w_emit && (r_step == '0);
  assign w_take = w_load && r_pend_valid;
  assign w_in   = {bus.sample_in_r, bus.sample_in_l};

  always_comb begin
    w_curr_new  = '0;
    w_delta_new = '0;
    w_acc_nxt   = '0;
    for (int c = 0; c < NCH; c++) begin
      // On a load the old curr becomes prev; curr advances only if pend is valid,
      // otherwise delta is 0 and the output sits flat at curr.
      w_curr_new[c]  = w_take ? r_pend[c] : r_curr[c];
      w_delta_new[c] = {w_curr_new[c][17], w_curr_new[c]} - {r_curr[c][17], r_curr[c]};
      // Accumulator holds prev*2^S + step*delta; its top 18 bits above the
      // fraction are the floor of the interpolated value.
      w_acc_nxt[c]   = w_load ? {r_curr[c][17], r_curr[c], {STEP_LOG2{1'b0}}}
                              : r_acc[c] + {{STEP_LOG2{r_delta[c][18]}}, r_delta[c]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick       <= '0;
      r_step       <= '0;
      r_pend_valid <= 1'b0;
      r_rdy        <= 1'b0;
      r_under      <= 1'b0;
      r_over       <= 1'b0;
      r_pend       <= '0;
      r_curr       <= '0;
      r_delta      <= '0;
      r_acc        <= '0;
      r_out        <= '0;
    end else begin
      r_tick  <= w_emit ? '0 : r_tick + 1'b1;
      r_rdy   <= w_emit;
      r_under <= w_load && !r_pend_valid;
      // A strobe coinciding with the load that drains pend is not an overrun.
      r_over  <= bus.sample_in_rdy && r_pend_valid && !w_take;
      if (w_emit) r_step <= r_step + 1'b1;
      if (bus.sample_in_rdy)  r_pend_valid <= 1'b1;
      else if (w_take)        r_pend_valid <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if (bus.sample_in_rdy) r_pend[c] <= w_in[c];
        if (w_load) begin
          r_curr[c]  <= w_curr_new[c];
          r_delta[c] <= w_delta_new[c];
        end
        if (w_emit) begin
          r_acc[c] <= w_acc_nxt[c];
          r_out[c] <= w_acc_nxt[c][STEP_LOG2+17:STEP_LOG2];
        end
      end
    end
  end

  assign bus.sample_out_l   = r_out[0];
  assign bus.sample_out_r   = r_out[1];
  assign bus.sample_out_rdy = r_rdy;
  assign bus.underrun       = r_under;
  assign bus.overrun        = r_over;
endmodule

// File: tb/tb_sample_linear_upsampler.sv
// Bench for sample_linear_upsampler (OUT_DIV=16, STEP_LOG2=2). The driver pushes
// a frame's four expected outputs at each frame load; the monitor pops and
// compares them on every output strobe.
module tb_sample_linear_upsampler;
  localparam int OUT_DIV   = 16;
  localparam int STEP_LOG2 = 2;
  localparam int NSTEP     = 1 << STEP_LOG2;
  localparam int FRAME     = NSTEP * OUT_DIV;

  logic clk = 1'b0;
  logic reset;
  sample_linear_upsampler_if bus();

  sample_linear_upsampler #(.OUT_DIV(OUT_DIV), .STEP_LOG2(STEP_LOG2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] l;
    logic [17:0] r;
    logic        und;
  } exp_t;

  exp_t        q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          e      = 0;   // edges since last frame load
  int          m_ovr_exp = 0;
  int          ovr_seen  = 0;
  logic        rdy_d     = 1'b0;
  logic [17:0] m_curr_l, m_curr_r, m_pend_l, m_pend_r;
  bit          m_pv;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Direct linear interpolation with floor rounding.
  function automatic logic [17:0] interp(logic [17:0] p, logic [17:0] c, int k);
    int pi, ci, acc;
    pi  = $signed(p);
    ci  = $signed(c);
    acc = (pi * NSTEP + k * (ci - pi)) >>> STEP_LOG2;
    return acc[17:0];
  endfunction

  task automatic push_frame(logic [17:0] pl, logic [17:0] pr,
                            logic [17:0] cl, logic [17:0] cr, bit und);
    exp_t x;
    for (int k = 0; k < NSTEP; k++) begin
      x.l   = interp(pl, cl, k);
      x.r   = interp(pr, cr, k);
      x.und = und && (k == 0);
      q.push_back(x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic put(int gap, logic [17:0] l, logic [17:0] r);
    repeat (gap) tick();
    bus.sample_in_l   = l;
    bus.sample_in_r   = r;
    bus.sample_in_rdy = 1'b1;
    if (m_pv) m_ovr_exp++;
    m_pv     = 1'b1;
    m_pend_l = l;
    m_pend_r = r;
    tick();
    bus.sample_in_rdy = 1'b0;
  endtask

  // Runs to the next frame load; optionally strobes a new input on the load edge.
  task automatic next_frame(bit strobe, logic [17:0] l, logic [17:0] r);
    logic [17:0] pl, pr;
    bit          und;
    while (e < FRAME - 1) tick();
    pl  = m_curr_l;
    pr  = m_curr_r;
    und = !m_pv;
    if (m_pv) begin
      m_curr_l = m_pend_l;
      m_curr_r = m_pend_r;
      m_pv     = 1'b0;
    end
    push_frame(pl, pr, m_curr_l, m_curr_r, und);
    if (strobe) begin
      bus.sample_in_l   = l;
      bus.sample_in_r   = r;
      bus.sample_in_rdy = 1'b1;
      m_pend_l = l;
      m_pend_r = r;
      m_pv     = 1'b1;
    end
    tick();
    bus.sample_in_rdy = 1'b0;
    e = 0;
  endtask

  always @(negedge clk) begin : mon
    exp_t x;
    if (reset) begin
      rdy_d <= 1'b0;
    end else begin
      chk("rdy_back2back", {31'd0, rdy_d & bus.sample_out_rdy}, 0);
      chk("und_stray", {31'd0, bus.underrun & ~bus.sample_out_rdy}, 0);
      if (bus.sample_out_rdy) begin
        if (q.size() == 0) begin
          chk("unexp_out", q.size(), 1);
        end else begin
          x = q.pop_front();
          chk("out_l", {14'd0, bus.sample_out_l}, {14'd0, x.l});
          chk("out_r", {14'd0, bus.sample_out_r}, {14'd0, x.r});
          chk("underrun", {31'd0, bus.underrun}, {31'd0, x.und});
        end
      end
      if (bus.overrun) ovr_seen <= ovr_seen + 1;
      rdy_d <= bus.sample_out_rdy;
    end
  end

  initial begin
    int nrdy;
    reset = 1'b1;
    bus.sample_in_l = '0; bus.sample_in_r = '0; bus.sample_in_rdy = 1'b0;
    m_curr_l = '0; m_curr_r = '0; m_pend_l = '0; m_pend_r = '0; m_pv = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_l", {14'd0, bus.sample_out_l}, 0);
    chk("rst_out_r", {14'd0, bus.sample_out_r}, 0);
    chk("rst_rdy", {31'd0, bus.sample_out_rdy}, 0);
    chk("rst_under", {31'd0, bus.underrun}, 0);
    chk("rst_over", {31'd0, bus.overrun}, 0);

    // Reset again partway through the first frame; tick must restart.
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_frame('0, '0, '0, '0, 1'b1);
    nrdy = 0;
    repeat (OUT_DIV - 1) begin
      @(posedge clk);
      #1;
      if (bus.sample_out_rdy) nrdy++;
    end
    chk("rst_no_early_rdy", nrdy, 0);
    @(posedge clk);
    #1;
    chk("rst_rdy_at_div", {31'd0, bus.sample_out_rdy}, 1);
    e = 0;

    // ramp
    put(10, 18'h00400, 18'h3FC00);
    next_frame(1'b0, '0, '0);
    put(5, 18'h00800, 18'h3F800);
    next_frame(1'b0, '0, '0);
    // underrun: flat at 0x800
    next_frame(1'b0, '0, '0);
    // negative target with floor rounding
    put(3, 18'h00000, 18'h00000);
    next_frame(1'b0, '0, '0);
    put(7, 18'h3FFFB, 18'h00005);
    next_frame(1'b0, '0, '0);
    // overrun: second input wins
    put(2, 18'h00100, 18'h3FF00);
    put(20, 18'h00200, 18'h3FE00);
    next_frame(1'b0, '0, '0);
    chk("ovr_count", ovr_seen, m_ovr_exp);
    // full scale swing, then input strobe on the load edge
    put(4, 18'h1FFFF, 18'h20000);
    next_frame(1'b0, '0, '0);
    put(4, 18'h20000, 18'h1FFFF);
    next_frame(1'b1, 18'h00123, 18'h3FEDC);
    next_frame(1'b0, '0, '0);
    chk("ovr_count_load", ovr_seen, m_ovr_exp);

    repeat (FRAME) tick();
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
